uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart_tx instance between NREQ byte-stream requesters. Round-robin
//   arbitration at packet granularity: a granted requester keeps the transmitter
//   until it sends a byte flagged last, or until it stalls for longer than HOLD_MAX.
//   Sits between the producer blocks (ALU result path, debug/status sources) and
//   the tx_start/din/tx_done_tick interface of uart_tx.
// PARAMETERS
//   NREQ      4     number of requesters (2..8)
//   HOLD_MAX  1024  max clk cycles the owner may stall mid-packet before grant is revoked
// PORTS
//   clk           in   1       system clock; all logic on rising edge
//   reset         in   1       asynchronous, active-low reset
//   req           in   NREQ    per-requester: byte available on req_data/req_last
//   req_data      in   8*NREQ  byte of requester i on [8*i+7:8*i]
//   req_last      in   NREQ    byte of requester i is the final byte of its packet
//   ack           out  NREQ    one-cycle pulse: byte of requester i captured
//   grant         out  NREQ    one-hot current owner; all zero when idle
//   busy          out  1       high in any state other than IDLE
//   hold_err      out  1       one-cycle pulse: owner timed out mid-packet
//   tx_start      out  1       to uart_tx.tx_start
//   tx_din        out  8       to uart_tx.din
//   tx_done_tick  in   1       from uart_tx.tx_done_tick
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; ack, grant, busy, hold_err, tx_start=0; tx_din=0;
//     rr pointer=NREQ-1 (req[0] wins first); hold counter=0. Mid-frame reset aborts
//     silently; no ack or hold_err issued.
//   States: IDLE, SEND, WAIT, HOLD. All outputs registered.
//   IDLE: if |req, pick first set bit scanning from (ptr+1) mod NREQ upward with wrap;
//     same edge: latch req_data/req_last of the winner into byte_reg/last_reg, ack[w]=1
//     for 1 cycle, grant=onehot(w), ptr=w, -> SEND. req-to-ack latency = 1 clk.
//   SEND: tx_start=1 for exactly this one cycle, tx_din=byte_reg; -> WAIT.
//   WAIT: tx_start=0, tx_din held stable; on tx_done_tick:
//     last_reg=1            -> IDLE, grant=0 (arbitration resumes the next cycle)
//     last_reg=0, req[own]=1 -> latch next byte, ack[own] pulse, -> SEND
//     last_reg=0, req[own]=0 -> HOLD, hold counter=0.
//   HOLD: counter +1 per clk; req[own]=1 -> latch, ack, -> SEND (counter cleared);
//     counter==HOLD_MAX-1 with req[own]=0 -> hold_err pulse, grant=0, -> IDLE.
//   Requests from non-owners are ignored outside IDLE (no ack, no loss; they wait).
//   tx_done_tick outside WAIT is ignored. Exactly one byte per tx_start.
//   Requester contract: req_data/req_last stable while req high and before ack;
//     dropping req before ack (withdrawal) is legal and produces no ack.
//   ack is never asserted for more than one requester or for more than one cycle.
//   Counter width: $clog2(HOLD_MAX+1); no wrap (the timeout fires first).
// TESTING
//   1. req=4'b0001, byte 0x41, last=1 -> ack[0] 1 clk later, one tx_start with tx_din=0x41,
//      busy until tx_done_tick, grant back to 0.
//   2. req=4'b1111 held, all last=1 -> service order 0,1,2,3,0 over five frames; one ack each.
//   3. req0 3-byte packet 0x10,0x11,0x12(last) with req2 pending -> the three bytes go
//      back to back before req2 is acked; req2 is granted next.
//   4. Owner drops req after byte 1 (last=0) for HOLD_MAX cycles -> hold_err pulse at
//      cycle HOLD_MAX of HOLD, grant=0, next requester served; no extra tx_start.
//   5. Owner resumes req after 10 cycles in HOLD -> ack, tx_start, no hold_err.
//   6. reset=0 asserted during WAIT -> all outputs 0 asynchronously; after release,
//      req=4'b1010 -> req[1] granted first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester and uart_tx-side signals of the shared-transmitter arbiter.
// slave = arbiter side, master = requesters plus uart_tx (or a bench).
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              hold_err;
  logic              tx_start;
  logic [7:0]        tx_din;
  logic              tx_done_tick;

  modport slave (
    input  req, req_data, req_last, tx_done_tick,
    output ack, grant, busy, hold_err, tx_start, tx_din
  );

  modport master (
    output req, req_data, req_last, tx_done_tick,
    input  ack, grant, busy, hold_err, tx_start, tx_din
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular sharing of one uart_tx between NREQ byte streams.
// The owner keeps the transmitter until its last byte, or until it stalls HOLD_MAX cycles.
module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned HOLD_MAX = 1024
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_t;

  state_t          r_state, w_nxt_state;
  logic [IW-1:0]   r_ptr, w_nxt_ptr;
  logic [7:0]      r_byte, w_nxt_byte;
  logic            r_last, w_nxt_last;
  logic [CW-1:0]   r_cnt, w_nxt_cnt;
  logic [NREQ-1:0] r_ack, w_nxt_ack;
  logic [NREQ-1:0] r_grant, w_nxt_grant;
  logic            r_busy, w_nxt_busy;
  logic            r_hold_err, w_nxt_hold_err;
  logic            r_tx_start, w_nxt_tx_start;
  logic [7:0]      r_tx_din, w_nxt_tx_din;

  logic            w_found;
  logic [IW-1:0]   w_win;
  logic            w_own_req;
  logic [7:0]      w_own_data;
  logic            w_own_last;

  // Winner: first requester at or after ptr+1, wrapping; the previous owner goes last.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!w_found && bus.req[(32'(r_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_win   = IW'((32'(r_ptr) + k) % NREQ);
      end
    end
  end

  assign w_own_req  = bus.req[r_ptr];
  assign w_own_data = bus.req_data[{r_ptr, 3'b000} +: 8];
  assign w_own_last = bus.req_last[r_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= IW'(NREQ - 1);
      r_byte     <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      r_ack      <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_hold_err <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_din   <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_ptr      <= w_nxt_ptr;
      r_byte     <= w_nxt_byte;
      r_last     <= w_nxt_last;
      r_cnt      <= w_nxt_cnt;
      r_ack      <= w_nxt_ack;
      r_grant    <= w_nxt_grant;
      r_busy     <= w_nxt_busy;
      r_hold_err <= w_nxt_hold_err;
      r_tx_start <= w_nxt_tx_start;
      r_tx_din   <= w_nxt_tx_din;
    end
  end

  // Next state and next registered outputs; ack/tx_start/hold_err are single-cycle pulses.
  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_ptr      = r_ptr;
    w_nxt_byte     = r_byte;
    w_nxt_last     = r_last;
    w_nxt_cnt      = r_cnt;
    w_nxt_ack      = '0;
    w_nxt_grant    = r_grant;
    w_nxt_hold_err = 1'b0;
    w_nxt_tx_start = 1'b0;
    w_nxt_tx_din   = r_tx_din;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_nxt_byte  = bus.req_data[{w_win, 3'b000} +: 8];
          w_nxt_last  = bus.req_last[w_win];
          w_nxt_ack   = NREQ'(1) << w_win;
          w_nxt_grant = NREQ'(1) << w_win;
          w_nxt_ptr   = w_win;
          w_nxt_state = S_SEND;
        end
      end
      S_SEND: begin
        w_nxt_tx_start = 1'b1;
        w_nxt_tx_din   = r_byte;
        w_nxt_state    = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done_tick) begin
          if (r_last) begin
            w_nxt_grant = '0;
            w_nxt_state = S_IDLE;
          end else if (w_own_req) begin
            w_nxt_byte  = w_own_data;
            w_nxt_last  = w_own_last;
            w_nxt_ack   = r_grant;
            w_nxt_state = S_SEND;
          end else begin
            w_nxt_cnt   = '0;
            w_nxt_state = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (w_own_req) begin
          w_nxt_byte  = w_own_data;
          w_nxt_last  = w_own_last;
          w_nxt_ack   = r_grant;
          w_nxt_cnt   = '0;
          w_nxt_state = S_SEND;
        end else if (r_cnt == CW'(HOLD_MAX - 1)) begin
          w_nxt_hold_err = 1'b1;
          w_nxt_grant    = '0;
          w_nxt_state    = S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt + CW'(1);
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase

    w_nxt_busy = (w_nxt_state != S_IDLE);
  end

  assign bus.ack      = r_ack;
  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.hold_err = r_hold_err;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_din   = r_tx_din;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued requester model, uart_tx stand-in and an
// expected-transmission scoreboard, plus an arbitration vector table.
module tb_uart_tx_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned HOLD_MAX = 1024;
  localparam int          UART_LAT = 5;
  localparam int          N_FRAMES = 23;

  typedef struct packed {logic [7:0] d; logic l;} byte_t;
  typedef struct packed {logic [1:0] idx; logic [7:0] d;} exp_t;
  typedef struct {logic [3:0] mask; int win;} vec_t;

  logic clk = 1'b0;
  logic reset;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  byte_t rq[NREQ][$];
  exp_t  sb[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    n_start = 0;
  int    n_herr = 0;
  int    ack_cnt[NREQ];
  int    uart_cnt = 0;
  logic  prev_start = 1'b0;
  vec_t  vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < int'(NREQ); i++) begin
      if (rq[i].size() > 0) begin
        bus.req[i]              = 1'b1;
        bus.req_data[8*i +: 8]  = rq[i][0].d;
        bus.req_last[i]         = rq[i][0].l;
      end else begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic l);
    rq[r].push_back({d, l});
  endtask

  task automatic expect_tx(input int r, input logic [7:0] d);
    sb.push_back({2'(r), d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string nm, input int r);
    int c = 0;
    while (bus.ack[r] !== 1'b1 && c < 50) begin
      tick();
      c++;
    end
    chk(nm, 32'(bus.ack), 32'(1) << r);
  endtask

  task automatic wait_done_tick(input string nm);
    int c = 0;
    while (bus.tx_done_tick !== 1'b1 && c < 100) begin
      tick();
      c++;
    end
    chk(nm, 32'(bus.tx_done_tick), 32'd1);
  endtask

  task automatic wait_done(input string nm, input int budget);
    int c = 0;
    while (!(sb.size() == 0 && bus.busy === 1'b0) && c < budget) begin
      tick();
      c++;
    end
    chk(nm, 32'(sb.size() == 0 && bus.busy === 1'b0), 32'd1);
  endtask

  // uart_tx stand-in, protocol monitor and scoreboard, all on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      uart_cnt         = 0;
      bus.tx_done_tick = 1'b0;
    end else begin
      bus.tx_done_tick = 1'b0;
      if (uart_cnt > 0) begin
        uart_cnt--;
        if (uart_cnt == 0) bus.tx_done_tick = 1'b1;
      end
      if (bus.tx_start) uart_cnt = UART_LAT;
    end
    if (bus.ack != '0) begin
      chk("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
      chk("ack_is_owner", 32'(bus.ack), 32'(bus.grant));
      for (int i = 0; i < int'(NREQ); i++) begin
        if (bus.ack[i]) begin
          ack_cnt[i]++;
          if (rq[i].size() > 0) void'(rq[i].pop_front());
        end
      end
      drive_reqs();
    end
    if (bus.hold_err) n_herr++;
    if (bus.tx_start) begin
      exp_t e;
      n_start++;
      chk("tx_start_pulse", 32'(prev_start), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_tx_start", 32'(bus.tx_din), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_tx_din", 32'(bus.tx_din), 32'(e.d));
        chk("sb_grant", 32'(bus.grant), 32'(1) << e.idx);
      end
    end
    prev_start = bus.tx_start;
  end

  initial begin
    vt[0] = '{4'b1010, 1};
    vt[1] = '{4'b1010, 3};
    vt[2] = '{4'b0110, 1};
    vt[3] = '{4'b0011, 0};
    vt[4] = '{4'b1001, 3};
    vt[5] = '{4'b1000, 3};
    vt[6] = '{4'b0101, 0};
    vt[7] = '{4'b0101, 2};
    for (int i = 0; i < int'(NREQ); i++) ack_cnt[i] = 0;

    reset        = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) tick();
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_hold_err", 32'(bus.hold_err), 32'd0);
    chk("rst_tx_start", 32'(bus.tx_start), 32'd0);
    chk("rst_tx_din", 32'(bus.tx_din), 32'd0);
    reset = 1'b1;
    tick();

    // single one-byte packet: ack one clock after req, then one tx_start
    add_byte(0, 8'h41, 1'b1);
    expect_tx(0, 8'h41);
    drive_reqs();
    tick();
    chk("t1_ack", 32'(bus.ack), 32'h1);
    chk("t1_grant", 32'(bus.grant), 32'h1);
    tick();
    chk("t1_tx_start", 32'(bus.tx_start), 32'd1);
    chk("t1_tx_din", 32'(bus.tx_din), 32'h41);
    wait_done("t1_done", 100);
    chk("t1_grant_idle", 32'(bus.grant), 32'd0);

    // all four requesting, owner pointer at 0 -> 1,2,3,0,1
    add_byte(0, 8'h20, 1'b1);
    add_byte(1, 8'h21, 1'b1);
    add_byte(1, 8'h31, 1'b1);
    add_byte(2, 8'h22, 1'b1);
    add_byte(3, 8'h23, 1'b1);
    expect_tx(1, 8'h21);
    expect_tx(2, 8'h22);
    expect_tx(3, 8'h23);
    expect_tx(0, 8'h20);
    expect_tx(1, 8'h31);
    drive_reqs();
    wait_done("t2_done", 300);
    chk("t2_acks0", 32'(ack_cnt[0]), 32'd2);
    chk("t2_acks1", 32'(ack_cnt[1]), 32'd2);
    chk("t2_acks2", 32'(ack_cnt[2]), 32'd1);
    chk("t2_acks3", 32'(ack_cnt[3]), 32'd1);

    // multi-byte packet keeps the transmitter while req2 waits
    add_byte(0, 8'h10, 1'b0);
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h12, 1'b1);
    expect_tx(0, 8'h10);
    expect_tx(0, 8'h11);
    expect_tx(0, 8'h12);
    drive_reqs();
    wait_ack("t3_ack0", 0);
    add_byte(2, 8'h55, 1'b1);
    expect_tx(2, 8'h55);
    drive_reqs();
    wait_done("t3_done", 300);
    chk("t3_acks0", 32'(ack_cnt[0]), 32'd5);
    chk("t3_acks2", 32'(ack_cnt[2]), 32'd2);

    // owner 3 stalls mid-packet; timeout on the HOLD_MAX-th HOLD cycle
    add_byte(3, 8'h60, 1'b0);
    expect_tx(3, 8'h60);
    drive_reqs();
    wait_ack("t4_ack3", 3);
    add_byte(1, 8'h70, 1'b1);
    expect_tx(1, 8'h70);
    drive_reqs();
    wait_done_tick("t4_done_tick");
    for (int k = 1; k <= int'(HOLD_MAX); k++) begin
      tick();
      if (k == int'(HOLD_MAX) - 1) begin
        chk("t4_no_err_early", 32'(bus.hold_err), 32'd0);
        chk("t4_grant_hold", 32'(bus.grant), 32'h8);
      end
      if (k == int'(HOLD_MAX)) begin
        chk("t4_hold_err", 32'(bus.hold_err), 32'd1);
        chk("t4_grant_drop", 32'(bus.grant), 32'd0);
      end
    end
    tick();
    chk("t4_err_pulse", 32'(bus.hold_err), 32'd0);
    chk("t4_next_ack", 32'(bus.ack), 32'h2);
    wait_done("t4_done", 100);

    // owner 2 resumes after 10 HOLD cycles
    add_byte(2, 8'h80, 1'b0);
    expect_tx(2, 8'h80);
    expect_tx(2, 8'h81);
    drive_reqs();
    wait_done_tick("t5_done_tick");
    repeat (10) tick();
    add_byte(2, 8'h81, 1'b1);
    drive_reqs();
    tick();
    chk("t5_ack", 32'(bus.ack), 32'h4);
    tick();
    chk("t5_tx_start", 32'(bus.tx_start), 32'd1);
    chk("t5_tx_din", 32'(bus.tx_din), 32'h81);
    wait_done("t5_done", 100);
    chk("t5_herr_total", 32'(n_herr), 32'd1);

    // asynchronous reset while waiting on the transmitter
    add_byte(0, 8'h90, 1'b1);
    expect_tx(0, 8'h90);
    drive_reqs();
    repeat (3) tick();
    chk("t6_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_grant", 32'(bus.grant), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_tx_din", 32'(bus.tx_din), 32'd0);
    chk("t6_pulses", 32'({bus.ack, bus.tx_start, bus.hold_err}), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // arbitration vectors from a fresh pointer; losers withdraw before ack
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < int'(NREQ); i++)
        if (vt[v].mask[i]) add_byte(i, 8'(v * 16 + i + 1), 1'b1);
      expect_tx(vt[v].win, 8'(v * 16 + vt[v].win + 1));
      drive_reqs();
      wait_ack($sformatf("vec%0d_ack", v), vt[v].win);
      for (int i = 0; i < int'(NREQ); i++)
        if (i != vt[v].win) rq[i].delete();
      drive_reqs();
      wait_done($sformatf("vec%0d_done", v), 100);
    end

    repeat (5) tick();
    chk("end_frames", 32'(n_start), 32'(N_FRAMES));
    chk("end_sb_empty", 32'(sb.size()), 32'd0);
    chk("end_herr", 32'(n_herr), 32'd1);
    chk("end_grant", 32'(bus.grant), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
